// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-address sequencer.
// Holds the default vectors, next-PC source codes and branch arithmetic.
package pc_pkg;

  localparam logic [31:0] RESET_VEC_D = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_D   = 32'h0000_4180;

  typedef enum logic [2:0] {
    EXC,
    HOLD,
    RAS,
    JR,
    JMP,
    BR,
    SEQ
  } pc_src_e;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } pc_state_e;

  // Computed at 64 bits; callers keep the low ADDR_W bits (modulo wrap).
  function automatic logic [63:0] br_target(
    input logic [63:0] pc,
    input logic [15:0] off
  );
    return pc + 64'd4 + {{46{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for call/return prediction.
// A push when full overwrites the oldest entry and sets a sticky flag.
module pc_ras
  import pc_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_top;
  logic [PW:0]   cnt;
  logic          ovf;
  logic          do_pop;

  assign sp_top = sp - PW'(1);
  assign do_pop = pop && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && do_pop) begin
      mem[sp_top] <= din;
    end else if (push) begin
      mem[sp] <= din;
      sp      <= sp + PW'(1);
      if (cnt == CNT_MAX) ovf <= 1'b1;
      else                cnt <= cnt + (PW+1)'(1);
    end else if (do_pop) begin
      sp  <= sp_top;
      cnt <= cnt - (PW+1)'(1);
    end
  end

  assign top      = mem[sp_top];
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_MAX);
  assign overflow = ovf;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register, next-PC priority mux and boot sequencing.
// Redirect requests from decode/execute land on PC one edge later.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = RESET_VEC_D,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_D,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              PcReSet_n,
  input  logic              Stall,
  input  logic              BrTaken,
  input  logic [15:0]       BrOffset,
  input  logic              Jump,
  input  logic [25:0]       JumpAddr,
  input  logic              JrEn,
  input  logic [ADDR_W-1:0] JrAddr,
  input  logic              RetHint,
  input  logic              Link,
  input  logic              Exc,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] NextPc,
  output logic              PcValid,
  output logic              AdelFlag,
  output logic              RasEmpty,
  output logic              RasFull,
  output logic              RasOverflow
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC = ADDR_W'(EXC_VEC);

  pc_state_e         state;
  pc_state_e         state_nxt;
  pc_src_e           src;
  logic              adel;
  logic              run;
  logic              ras_ok;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] p4;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [63:0]       br_wide;

  assign p4      = PC + ADDR_W'(4);
  assign br_wide = br_target(64'(PC), BrOffset);
  assign br_tgt  = br_wide[ADDR_W-1:0];
  assign jmp_tgt = {p4[ADDR_W-1:28], JumpAddr, 2'b00};

  always_ff @(posedge Clk or negedge PcReSet_n) begin
    if (!PcReSet_n) state <= ST_BOOT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    src       = SEQ;
    adel      = 1'b0;
    if (state == ST_BOOT) begin
      state_nxt = ST_RUN;
      src       = HOLD;
    end else if (Exc) begin
      src = EXC;
    end else if (Stall) begin
      src = HOLD;
    end else if (JrEn) begin
      if (RetHint && !RasEmpty) begin
        src = RAS;
      end else if (JrAddr[1:0] != 2'b00) begin
        src  = EXC;
        adel = 1'b1;
      end else begin
        src = JR;
      end
    end else if (Jump) begin
      src = JMP;
    end else if (BrTaken) begin
      src = BR;
    end
  end

  always_comb begin
    unique case (src)
      EXC:     NextPc = EXC_PC;
      HOLD:    NextPc = PC;
      RAS:     NextPc = ras_top;
      JR:      NextPc = JrAddr;
      JMP:     NextPc = jmp_tgt;
      BR:      NextPc = br_tgt;
      default: NextPc = p4;
    endcase
  end

  always_ff @(posedge Clk or negedge PcReSet_n) begin
    if (!PcReSet_n) begin
      PC       <= RST_PC;
      PcValid  <= 1'b0;
      AdelFlag <= 1'b0;
    end else begin
      PC       <= NextPc;
      PcValid  <= 1'b1;
      AdelFlag <= adel;
    end
  end

  // Stack only moves on instructions that actually retire a redirect.
  assign run      = (state == ST_RUN);
  assign ras_ok   = run && !Stall && !Exc;
  assign ras_push = ras_ok && Link;
  assign ras_pop  = ras_ok && JrEn && RetHint && !RasEmpty;

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (Clk),
    .rst_n    (PcReSet_n),
    .push     (ras_push),
    .pop      (ras_pop),
    .din      (p4),
    .top      (ras_top),
    .empty    (RasEmpty),
    .full     (RasFull),
    .overflow (RasOverflow)
  );

endmodule
